// File: rtl/ex_div.sv
// Iterative 32-bit restoring divider for the execute stage: one quotient bit per cycle,
// signed/unsigned, divide-by-zero and pipeline-flush aware. Stalls IF/ID and ID/EX while busy.
module ex_div (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  ex_aluop_i,
   input  logic [31:0] ex_reg1_i,
   input  logic [31:0] ex_reg2_i,
   input  logic        cancel_i,
   output logic        stallreq_o,
   output logic        div_done_o,
   output logic [31:0] div_lo_o,
   output logic [31:0] div_hi_o,
   output logic        div_by_zero_o
);

   localparam logic [6:0] AluopDiv  = 7'b0011010;
   localparam logic [6:0] AluopDivu = 7'b0011011;

   typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_e;

   state_e      state_q, state_d;
   logic [5:0]  count_q, count_d;
   logic [64:0] work_q, work_d;
   logic [31:0] divisor_q, divisor_d;
   logic        signed_q, signed_d;
   logic        dvd_neg_q, dvd_neg_d;
   logic        quot_neg_q, quot_neg_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_q, hi_d;
   logic        dbz_q, dbz_d;

   logic        is_div, is_signed_op, a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [64:0] shifted, iter_work;
   logic [33:0] trial;
   logic [31:0] quot_final, rem_final;

   assign is_div       = (ex_aluop_i == AluopDiv) || (ex_aluop_i == AluopDivu);
   assign is_signed_op = (ex_aluop_i == AluopDiv);
   assign a_neg        = is_signed_op & ex_reg1_i[31];
   assign b_neg        = is_signed_op & ex_reg2_i[31];
   // 0x80000000 negates to itself, which is already the correct unsigned magnitude.
   assign a_mag        = a_neg ? (32'd0 - ex_reg1_i) : ex_reg1_i;
   assign b_mag        = b_neg ? (32'd0 - ex_reg2_i) : ex_reg2_i;

   // Partial remainder can exceed 32 bits after the shift, so trial is kept 34 bits wide.
   assign shifted    = {work_q[63:0], 1'b0};
   assign trial      = {1'b0, shifted[64:32]} - {2'b00, divisor_q};
   assign iter_work  = trial[33] ? shifted : {trial[32:0], shifted[31:1], 1'b1};
   assign quot_final = (signed_q & quot_neg_q) ? (32'd0 - iter_work[31:0]) : iter_work[31:0];
   assign rem_final  = (signed_q & dvd_neg_q) ? (32'd0 - iter_work[63:32]) : iter_work[63:32];

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      work_d     = work_q;
      divisor_d  = divisor_q;
      signed_d   = signed_q;
      dvd_neg_d  = dvd_neg_q;
      quot_neg_d = quot_neg_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      dbz_d      = dbz_q;
      if (cancel_i) begin
         state_d = StIdle;
         count_d = 6'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (is_div) begin
                  if (ex_reg2_i == 32'd0) begin
                     state_d = StByZero;
                  end else begin
                     work_d     = {33'd0, a_mag};
                     divisor_d  = b_mag;
                     signed_d   = is_signed_op;
                     dvd_neg_d  = a_neg;
                     quot_neg_d = a_neg ^ b_neg;
                     count_d    = 6'd0;
                     state_d    = StOn;
                  end
               end
            end
            StByZero: begin
               lo_d    = 32'd0;
               hi_d    = 32'd0;
               dbz_d   = 1'b1;
               state_d = StEnd;
            end
            StOn: begin
               work_d  = iter_work;
               count_d = count_q + 6'd1;
               if (count_q == 6'd31) begin
                  lo_d    = quot_final;
                  hi_d    = rem_final;
                  dbz_d   = 1'b0;
                  state_d = StEnd;
               end
            end
            StEnd:   state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         count_q    <= 6'd0;
         work_q     <= 65'd0;
         divisor_q  <= 32'd0;
         signed_q   <= 1'b0;
         dvd_neg_q  <= 1'b0;
         quot_neg_q <= 1'b0;
         lo_q       <= 32'd0;
         hi_q       <= 32'd0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         work_q     <= work_d;
         divisor_q  <= divisor_d;
         signed_q   <= signed_d;
         dvd_neg_q  <= dvd_neg_d;
         quot_neg_q <= quot_neg_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         dbz_q      <= dbz_d;
      end
   end

   assign stallreq_o    = rst_n & ~cancel_i &
                          ((state_q == StOn) || (state_q == StByZero) ||
                           ((state_q == StIdle) && is_div));
   assign div_done_o    = rst_n & ~cancel_i & (state_q == StEnd);
   assign div_lo_o      = lo_q;
   assign div_hi_o      = hi_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed scenarios plus randomized divides against an
// arithmetic reference model.
module tb_ex_div;

   localparam logic [6:0] OpDiv  = 7'b0011010;
   localparam logic [6:0] OpDivu = 7'b0011011;
   localparam logic [6:0] OpNop  = 7'b0000001;

   logic        clk;
   logic        rst_n;
   logic [6:0]  aluop;
   logic [31:0] reg1, reg2;
   logic        cancel;
   logic        stallreq, done;
   logic [31:0] lo, hi;
   logic        dbz;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   ex_div dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_aluop_i   (aluop),
      .ex_reg1_i    (reg1),
      .ex_reg2_i    (reg2),
      .cancel_i     (cancel),
      .stallreq_o   (stallreq),
      .div_done_o   (done),
      .div_lo_o     (lo),
      .div_hi_o     (hi),
      .div_by_zero_o(dbz)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1);
   end

   // Reference: plain arithmetic from the instruction semantics.
   function automatic void model(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r, output logic z);
      int sa, sb;
      z = 1'b0;
      if (b == 32'd0) begin
         q = 32'd0; r = 32'd0; z = 1'b1;
      end else if (op == OpDivu) begin
         q = a / b; r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 32'd0;
      end else begin
         sa = a; sb = b;
         q = sa / sb; r = sa % sb;
      end
   endfunction

   // Drives one op starting at posedge+1 and observes it at negedges until done or budget.
   task automatic run_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int cancel_at, input bit scramble,
                         output int stalls, output int done_at, output int dones,
                         output int done_cyc, output bit cancel_stall);
      stalls = 0; done_at = -1; dones = 0; done_cyc = -1; cancel_stall = 1'b0;
      aluop = op; reg1 = a; reg2 = b;
      for (int t = 0; t < 40; t++) begin
         cancel = (t == cancel_at);
         if (scramble && t > 0 && done_at < 0) begin
            reg1 = $urandom; reg2 = $urandom;
         end
         @(negedge clk);
         if (stallreq) stalls++;
         if (t == cancel_at) cancel_stall = stallreq;
         if (done) begin
            dones++;
            if (done_at < 0) begin done_at = t; done_cyc = cyc; end
         end
         @(posedge clk); #1;
         if (t == cancel_at) aluop = OpNop;
         if (done_at >= 0) break;
      end
      cancel = 1'b0;
      aluop  = OpNop;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; cancel = 1'b0; aluop = OpDivu; reg1 = 32'd100; reg2 = 32'd7;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (stallreq !== 1'b0) $display("FAIL reset_stallreq got %b want 0", stallreq); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
      n_checks++; if (lo !== 32'd0) $display("FAIL reset_lo got %h want 0", lo); else n_pass++;
      n_checks++; if (hi !== 32'd0) $display("FAIL reset_hi got %h want 0", hi); else n_pass++;
      n_checks++; if (dbz !== 1'b0) $display("FAIL reset_dbz got %b want 0", dbz); else n_pass++;
      aluop = OpNop;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_divu_basic;
      int s, d, n, c; bit cs;
      run_op(OpDivu, 32'd100, 32'd7, -1, 1'b0, s, d, n, c, cs);
      n_checks++; if (s !== 33) $display("FAIL divu_stall_cycles got %0d want 33", s); else n_pass++;
      n_checks++; if (d !== 33) $display("FAIL divu_done_at got T%0d want T33", d); else n_pass++;
      n_checks++; if (lo !== 32'd14) $display("FAIL divu_lo got %0d want 14", lo); else n_pass++;
      n_checks++; if (hi !== 32'd2) $display("FAIL divu_hi got %0d want 2", hi); else n_pass++;
      n_checks++; if (dbz !== 1'b0) $display("FAIL divu_dbz got %b want 0", dbz); else n_pass++;
   endtask

   task automatic test_signed;
      logic [31:0] ta [4] = '{32'hFFFF_FFF9, 32'd7,          32'hFFFF_FFF9, 32'd0};
      logic [31:0] tb [4] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd5};
      logic [31:0] tq [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3,         32'd0};
      logic [31:0] tr [4] = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0};
      int s, d, n, c; bit cs;
      for (int i = 0; i < 4; i++) begin
         run_op(OpDiv, ta[i], tb[i], -1, 1'b0, s, d, n, c, cs);
         n_checks++; if (lo !== tq[i]) $display("FAIL signed_lo[%0d] got %h want %h", i, lo, tq[i]); else n_pass++;
         n_checks++; if (hi !== tr[i]) $display("FAIL signed_hi[%0d] got %h want %h", i, hi, tr[i]); else n_pass++;
      end
   endtask

   task automatic test_by_zero;
      int s, d, n, c; bit cs;
      run_op(OpDiv, 32'd5, 32'd0, -1, 1'b0, s, d, n, c, cs);
      n_checks++; if (d !== 2) $display("FAIL dbz_done_at got T%0d want T2", d); else n_pass++;
      n_checks++; if (s !== 2) $display("FAIL dbz_stall_cycles got %0d want 2", s); else n_pass++;
      n_checks++; if (lo !== 32'd0 || hi !== 32'd0) $display("FAIL dbz_result got %h/%h want 0/0", lo, hi); else n_pass++;
      n_checks++; if (dbz !== 1'b1) $display("FAIL dbz_flag got %b want 1", dbz); else n_pass++;
      run_op(OpDivu, 32'hFFFF_FFFF, 32'd1, -1, 1'b0, s, d, n, c, cs);
      n_checks++; if (lo !== 32'hFFFF_FFFF) $display("FAIL after_dbz_lo got %h want ffffffff", lo); else n_pass++;
      n_checks++; if (hi !== 32'd0) $display("FAIL after_dbz_hi got %h want 0", hi); else n_pass++;
      n_checks++; if (dbz !== 1'b0) $display("FAIL after_dbz_flag got %b want 0", dbz); else n_pass++;
   endtask

   task automatic test_overflow;
      int s, d, n, c; bit cs;
      run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, s, d, n, c, cs);
      n_checks++; if (lo !== 32'h8000_0000) $display("FAIL ovf_div_lo got %h want 80000000", lo); else n_pass++;
      n_checks++; if (hi !== 32'd0) $display("FAIL ovf_div_hi got %h want 0", hi); else n_pass++;
      run_op(OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, s, d, n, c, cs);
      n_checks++; if (lo !== 32'd0) $display("FAIL ovf_divu_lo got %h want 0", lo); else n_pass++;
      n_checks++; if (hi !== 32'h8000_0000) $display("FAIL ovf_divu_hi got %h want 80000000", hi); else n_pass++;
   endtask

   task automatic test_cancel;
      int s, d, n, c; bit cs;
      logic [31:0] prev_lo, prev_hi;
      prev_lo = 32'd0; prev_hi = 32'h8000_0000;
      run_op(OpDivu, 32'd1000, 32'd3, 10, 1'b0, s, d, n, c, cs);
      n_checks++; if (cs !== 1'b0) $display("FAIL cancel_stallreq got %b want 0", cs); else n_pass++;
      n_checks++; if (s !== 10) $display("FAIL cancel_stall_cycles got %0d want 10", s); else n_pass++;
      n_checks++; if (n !== 0) $display("FAIL cancel_done_pulses got %0d want 0", n); else n_pass++;
      n_checks++; if (lo !== prev_lo || hi !== prev_hi)
         $display("FAIL cancel_hold got %h/%h want %h/%h", lo, hi, prev_lo, prev_hi); else n_pass++;
      run_op(OpDivu, 32'd9, 32'd3, -1, 1'b0, s, d, n, c, cs);
      n_checks++; if (d !== 33) $display("FAIL post_cancel_done_at got T%0d want T33", d); else n_pass++;
      n_checks++; if (lo !== 32'd3 || hi !== 32'd0) $display("FAIL post_cancel_result got %0d/%0d want 3/0", lo, hi); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int s, d, n, c1, c2; bit cs;
      run_op(OpDivu, 32'd50, 32'd5, -1, 1'b0, s, d, n, c1, cs);
      n_checks++; if (lo !== 32'd10 || hi !== 32'd0) $display("FAIL b2b_first got %0d/%0d want 10/0", lo, hi); else n_pass++;
      run_op(OpDivu, 32'd51, 32'd5, -1, 1'b0, s, d, n, c2, cs);
      n_checks++; if (lo !== 32'd10 || hi !== 32'd1) $display("FAIL b2b_second got %0d/%0d want 10/1", lo, hi); else n_pass++;
      n_checks++; if (c2 - c1 !== 34) $display("FAIL b2b_spacing got %0d want 34", c2 - c1); else n_pass++;
   endtask

   task automatic test_random;
      logic [31:0] sp [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0};
      logic [31:0] a, b, eq, er;
      logic [6:0]  op;
      logic        ez;
      int s, d, n, c; bit cs;
      for (int i = 0; i < 24; i++) begin
         op = ($urandom_range(0, 1) == 0) ? OpDiv : OpDivu;
         a  = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = sp[$urandom_range(0, 3)];
            2:       b = $urandom_range(1, 1000);
            3:       b = 32'd0 - $urandom_range(1, 1000);
            default: b = $urandom;
         endcase
         model(op, a, b, eq, er, ez);
         run_op(op, a, b, -1, bit'($urandom_range(0, 1)), s, d, n, c, cs);
         n_checks++; if (lo !== eq || hi !== er || dbz !== ez)
            $display("FAIL rand[%0d] op=%b %h/%h got %h/%h/%b want %h/%h/%b",
                     i, op, a, b, lo, hi, dbz, eq, er, ez); else n_pass++;
         n_checks++; if (d !== ((b == 32'd0) ? 2 : 33))
            $display("FAIL rand_done_at[%0d] got T%0d want T%0d", i, d, (b == 32'd0) ? 2 : 33); else n_pass++;
      end
   endtask

   task automatic test_reset_mid;
      int s, d, n, c; bit cs;
      int late;
      run_op(OpDivu, 32'd51, 32'd5, -1, 1'b0, s, d, n, c, cs);
      aluop = OpDivu; reg1 = 32'd1000; reg2 = 32'd7;
      repeat (15) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (lo !== 32'd0 || hi !== 32'd0 || dbz !== 1'b0)
         $display("FAIL midreset_regs got %h/%h/%b want 0/0/0", lo, hi, dbz); else n_pass++;
      n_checks++; if (stallreq !== 1'b0 || done !== 1'b0)
         $display("FAIL midreset_ctrl got %b/%b want 0/0", stallreq, done); else n_pass++;
      aluop = OpNop;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      late = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) late++;
      end
      n_checks++; if (late !== 0) $display("FAIL midreset_no_done got %0d want 0", late); else n_pass++;
      n_checks++; if (lo !== 32'd0 || hi !== 32'd0) $display("FAIL midreset_hold got %h/%h want 0/0", lo, hi); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_divu_basic;
      test_signed;
      test_by_zero;
      test_overflow;
      test_cancel;
      test_back_to_back;
      test_random;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
